// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth signed multiplier with a start/busy/done handshake.
// Optional BOOTH_MUL_ZERO_SKIP_EN: zero operands finish immediately without entering RUN.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_A,
  input  logic [WIDTH-1:0]   in_B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out_Prod
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int AW    = WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               bprev_q, bprev_d;
  logic [AW-1:0]      acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [AW-1:0]      mag, addend, sum, hi_shift;
  logic [WIDTH-1:0]   lo_shift;
  logic               neg;

  // Booth recoding of the current bit-pair plus the previously retired bit
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case ({mplier_q[1:0], bprev_q})
      3'b001, 3'b010: mag = {{2{mcand_q[WIDTH-1]}}, mcand_q};
      3'b011:         mag = {mcand_q[WIDTH-1], mcand_q, 1'b0};
      3'b100: begin
        mag = {mcand_q[WIDTH-1], mcand_q, 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = {{2{mcand_q[WIDTH-1]}}, mcand_q};
        neg = 1'b1;
      end
      default: begin
        mag = '0;
        neg = 1'b0;
      end
    endcase
    addend   = neg ? ~mag : mag;
    sum      = acc_hi_q + addend + {{(AW-1){1'b0}}, neg};
    hi_shift = {{2{sum[AW-1]}}, sum[AW-1:2]};
    lo_shift = {sum[1:0], acc_lo_q[WIDTH-1:2]};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    bprev_d  = bprev_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    step_d   = step_q;
    prod_d   = prod_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          mcand_d  = in_A;
          mplier_d = in_B;
          bprev_d  = 1'b0;
          acc_hi_d = '0;
          acc_lo_d = '0;
          step_d   = '0;
`ifdef BOOTH_MUL_ZERO_SKIP_EN
          if ((in_A == '0) || (in_B == '0)) begin
            state_d = DONE;
            prod_d  = '0;
          end
`endif
        end
      end
      RUN: begin
        acc_hi_d = hi_shift;
        acc_lo_d = lo_shift;
        mplier_d = {2'b00, mplier_q[WIDTH-1:2]};
        bprev_d  = mplier_q[1];
        step_d   = step_q + CNT_W'(1);
        // low WIDTH bits of the shifted high half carry the product's HI word
        if (step_q == LAST_STEP) begin
          state_d = DONE;
          prod_d  = {hi_shift[WIDTH-1:0], lo_shift};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      bprev_q  <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      step_q   <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      bprev_q  <= bprev_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      step_q   <= step_d;
      prod_q   <= prod_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign out_Prod = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: driver queues expected products and due cycles,
// a negedge monitor checks every done pulse and that out_Prod holds between results.
module tb_booth_mul_seq;
  localparam int W = 32;
  localparam int LAT = W / 2;
`ifdef BOOTH_MUL_ZERO_SKIP_EN
  localparam int ZLAT = 0;
  localparam bit ZBUSY = 1'b0;
`else
  localparam int ZLAT = LAT;
  localparam bit ZBUSY = 1'b1;
`endif

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   in_A = '0;
  logic [W-1:0]   in_B = '0;
  logic           busy, done;
  logic [2*W-1:0] out_Prod;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [2*W-1:0] held = '0;
  exp_t q[$];

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_A(in_A), .in_B(in_B),
    .busy(busy), .done(done), .out_Prod(out_Prod)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    return 64'(sa * sb);
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("product", out_Prod, e.prod);
          check("done_cycle", 64'(cyc), 64'(e.due));
          held = e.prod;
        end
      end else begin
        check("prod_hold", out_Prod, held);
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 3 * LAT) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (q.size() != 0) begin
      check({name, "_timeout"}, 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  // Single multiply; operands scrambled after the start edge to prove they are latched.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    exp_t e;
    bit zero;
    zero = (a == '0) || (b == '0);
    @(negedge clk);
    in_A = a;
    in_B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.prod = ref_mul(a, b);
    e.due  = cyc + (zero ? ZLAT : LAT);
    q.push_back(e);
    start = 1'b0;
    in_A = $urandom;
    in_B = $urandom;
    check({name, "_busy"}, 64'(busy), zero ? 64'(ZBUSY) : 64'd1);
    wait_drain(name);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    exp_t e;
    int c0, dc;
    logic [W-1:0] a, b;

    #12;
    check("reset_prod", out_Prod, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_mul(32'd7, 32'hFFFF_FFFD, "seven_neg3");
    check("seven_neg3_val", held, 64'hFFFF_FFFF_FFFF_FFEB);
    do_mul(32'h8000_0000, 32'h8000_0000, "minmin");
    check("minmin_val", held, 64'h4000_0000_0000_0000);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "negone");
    check("negone_val", held, 64'd1);
    do_mul(32'h7FFF_FFFF, 32'h8000_0000, "maxmin");
    do_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxmax");

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = 32'h8000_0000;
      if (i % 4 == 2) b = W'($urandom_range(0, 15)) - 32'd8;
      do_mul(a, b, "random");
    end

    // start re-pulsed at step 5 must be ignored
    @(negedge clk);
    in_A = 32'd12345; in_B = 32'hFFFF_F000; start = 1'b1;
    @(posedge clk); #1;
    e.prod = ref_mul(32'd12345, 32'hFFFF_F000); e.due = cyc + LAT; q.push_back(e);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    in_A = 32'd99; in_B = 32'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignore_restart");

    // start held high: two multiplies back to back
    @(negedge clk);
    in_A = 32'hDEAD_BEEF; in_B = 32'h0000_1234; start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    e.prod = ref_mul(32'hDEAD_BEEF, 32'h0000_1234); e.due = c0 + LAT; q.push_back(e);
    e.prod = ref_mul(32'h8765_4321, 32'hFFFF_8000); e.due = c0 + 2 * LAT + 1; q.push_back(e);
    in_A = 32'h8765_4321; in_B = 32'hFFFF_8000;
    repeat (LAT + 1) @(posedge clk);
    #1;
    start = 1'b0;
    in_A = '0; in_B = '0;
    wait_drain("back_to_back");

    // reset at step 8 discards the in-flight product
    @(negedge clk);
    in_A = 32'd1000; in_B = 32'd2000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_prod", out_Prod, 64'd0);
    held = '0;
    #3;
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (LAT + 4) @(negedge clk);
    #2;
    check("rst_no_done", 64'(done_cnt), 64'(dc));

    do_mul(32'h1234, 32'd0, "zero_b");
    check("zero_b_val", held, 64'd0);
    do_mul(32'd0, 32'hFFFF_FFFF, "zero_a");
    do_mul(32'd3, 32'd5, "after_zero");

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
